trace_char_arbiter: RTL and testbench

- Shares one cpu_checker character-stream parser between N CPU trace sources.
- Grants the checker to one source per message, message-atomically. A message is locked from its first accepted char until the '#' terminator, a bubble, or a length limit.
- Arbitration between sources is round-robin.
- Tags each checker verdict (format_type) with the source that produced it and reports it as a one-cycle result pulse.

---
 rtl/trace_arb_pkg.sv | 19 +
 rtl/rr_pick.sv | 32 +++
 rtl/trace_char_arbiter.sv | 144 ++++++++++++++
 tb/tb_trace_char_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_arb_pkg.sv
// Shared constants and types for the trace character arbiter.
package trace_arb_pkg;

  // ASCII framing characters seen by the cpu_checker parser.
  localparam logic [7:0] CHAR_CARET = 8'h5E;  // '^'
  localparam logic [7:0] CHAR_HASH  = 8'h23;  // '#'
  localparam logic [7:0] CHAR_FILL  = 8'h00;  // idle char, resets parser state

  // Checker verdict encodings (format_type / res_type).
  localparam logic [1:0] FMT_NONE = 2'd0;
  localparam logic [1:0] FMT_REG  = 2'd1;
  localparam logic [1:0] FMT_MEM  = 2'd2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin first-one finder: searches req starting just after ptr,
// wrapping modulo N, and returns a one-hot grant plus its index.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned SW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] idx
);

  logic [SW-1:0] j;
  logic          found;

  // Walk offsets 1..N from ptr; the first requester wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      j = SW'((32'(ptr) + k) % N);
      if (!found && req[j]) begin
        grant[j] = 1'b1;
        idx      = j;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/trace_char_arbiter.sv
// Shares one cpu_checker char parser between N trace sources. A source keeps the
// checker for a whole message ('#', bubble or MAX_LEN ends it); verdicts come back
// tagged with the source that produced them.
module trace_char_arbiter
  import trace_arb_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned SW      = 2,
  parameter int unsigned MAX_LEN = 64,
  parameter logic [7:0]  FILL    = CHAR_FILL
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req_valid,
  input  logic [8*N-1:0]  req_char,
  output logic [N-1:0]    req_ready,
  output logic [7:0]      chk_char,
  input  logic [1:0]      chk_format,
  output logic            res_valid,
  output logic [SW-1:0]   res_src,
  output logic [1:0]      res_type,
  output logic            abort_pulse
);

  localparam int unsigned LW = $clog2(MAX_LEN + 1);

  arb_state_e    state_q;
  logic [SW-1:0] owner_q;
  logic [SW-1:0] rr_ptr_q;
  logic [LW-1:0] len_q;
  logic          flush_q;   // forces one FILL cycle after a MAX_LEN release
  logic [7:0]    chk_char_q;
  logic          abort_q;
  logic          tag1_hash_q, tag2_hash_q;
  logic [SW-1:0] tag1_src_q, tag2_src_q;
  logic          res_valid_q;
  logic [SW-1:0] res_src_q;
  logic [1:0]    res_type_q;

  logic [N-1:0]  cand_grant;
  logic [SW-1:0] cand_idx;
  logic [SW-1:0] sel_idx;
  logic [7:0]    acc_char;
  logic          accept;
  logic          acc_hash;
  logic [7:0]    chars [N];

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign chars[g] = req_char[8*g +: 8];
  end

  rr_pick #(
    .N  (N),
    .SW (SW)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (cand_grant),
    .idx   (cand_idx)
  );

  // Ready/accept decode: candidate in IDLE, owner only while locked.
  always_comb begin
    req_ready = '0;
    sel_idx   = (state_q == LOCK) ? owner_q : cand_idx;
    if (state_q == LOCK) begin
      req_ready[owner_q] = 1'b1;
    end else if (!flush_q) begin
      req_ready = cand_grant;
    end
    accept   = |(req_valid & req_ready);
    acc_char = chars[sel_idx];
    acc_hash = accept && (acc_char == CHAR_HASH);
  end

  // Lock FSM, forwarded char, tag pipeline and registered result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= SW'(N - 1);
      len_q       <= '0;
      flush_q     <= 1'b0;
      chk_char_q  <= FILL;
      abort_q     <= 1'b0;
      tag1_hash_q <= 1'b0;
      tag1_src_q  <= '0;
      tag2_hash_q <= 1'b0;
      tag2_src_q  <= '0;
      res_valid_q <= 1'b0;
      res_src_q   <= '0;
      res_type_q  <= FMT_NONE;
    end else begin
      chk_char_q  <= accept ? acc_char : FILL;
      abort_q     <= 1'b0;
      flush_q     <= 1'b0;
      tag1_hash_q <= acc_hash;
      tag1_src_q  <= sel_idx;
      tag2_hash_q <= tag1_hash_q;
      tag2_src_q  <= tag1_src_q;
      // A verdict without a matching tag is not ours to report.
      res_valid_q <= tag2_hash_q;
      res_src_q   <= tag2_hash_q ? tag2_src_q : '0;
      res_type_q  <= tag2_hash_q ? chk_format : FMT_NONE;

      unique case (state_q)
        IDLE: begin
          if (accept) begin
            rr_ptr_q <= cand_idx;
            if (!acc_hash) begin
              owner_q <= cand_idx;
              len_q   <= LW'(1);
              state_q <= LOCK;
            end
          end
        end
        LOCK: begin
          if (accept) begin
            len_q <= len_q + 1'b1;
            if (acc_hash) begin
              state_q <= IDLE;
            end else if (len_q == LW'(MAX_LEN - 1)) begin
              state_q <= IDLE;
              abort_q <= 1'b1;
              flush_q <= 1'b1;
            end
          end else begin
            // Owner bubbled: drop the message, FILL resets the parser.
            state_q <= IDLE;
            abort_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign chk_char    = chk_char_q;
  assign abort_pulse = abort_q;
  assign res_valid   = res_valid_q;
  assign res_src     = res_src_q;
  assign res_type    = res_type_q;

endmodule

// File: tb/tb_trace_char_arbiter.sv
// Directed bench for trace_char_arbiter; a stand-in checker returns a chosen verdict
// one cycle after it sees '#' on chk_char.
module tb_trace_char_arbiter;
  import trace_arb_pkg::*;

  localparam int N  = 4;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [8*N-1:0]  req_char;
  logic [N-1:0]    req_ready;
  logic [7:0]      chk_char;
  logic [1:0]      chk_format;
  logic            res_valid;
  logic [SW-1:0]   res_src;
  logic [1:0]      res_type;
  logic            abort_pulse;
  logic [1:0]      fake_type;

  trace_char_arbiter #(
    .N       (N),
    .SW      (SW),
    .MAX_LEN (64),
    .FILL    (CHAR_FILL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_char    (req_char),
    .req_ready   (req_ready),
    .chk_char    (chk_char),
    .chk_format  (chk_format),
    .res_valid   (res_valid),
    .res_src     (res_src),
    .res_type    (res_type),
    .abort_pulse (abort_pulse)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in cpu_checker: registered verdict after '#' is presented.
  always @(posedge clk) begin
    if (reset) chk_format <= FMT_NONE;
    else       chk_format <= (chk_char == CHAR_HASH) ? fake_type : FMT_NONE;
  end

  typedef struct {
    int cyc;
    int src;
    int typ;
  } verdict_t;
  verdict_t vq[$];

  always @(negedge clk) begin
    if (res_valid === 1'b1) vq.push_back('{cyc, int'(res_src), int'(res_type)});
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int s, input logic v, input logic [7:0] c);
    req_valid[s]       = v;
    req_char[8*s +: 8] = c;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    req_char  = {N{CHAR_FILL}};
    tick();
    tick();
    chk("reset chk_char", chk_char, CHAR_FILL);
    chk("reset res_valid", res_valid, 0);
    chk("reset res_src", res_src, 0);
    chk("reset res_type", res_type, 0);
    chk("reset abort", abort_pulse, 0);
    reset = 1'b0;
    vq.delete();
  endtask

  task automatic expect_verdict(input string name, input int k, input int ecyc,
                                input int esrc, input int etyp);
    if (vq.size() > k) begin
      chk({name, " cyc"}, vq[k].cyc, ecyc);
      chk({name, " src"}, vq[k].src, esrc);
      chk({name, " type"}, vq[k].typ, etyp);
    end else begin
      chk({name, " missing"}, vq.size(), k + 1);
    end
  endtask

  // Sends a whole message from one source, checking grant and 1-cycle echo.
  task automatic send_msg(input string name, input int s, input string msg, output int e);
    logic [N-1:0] exp_rdy;
    exp_rdy    = '0;
    exp_rdy[s] = 1'b1;
    e = 0;
    for (int i = 0; i < msg.len(); i++) begin
      drive(s, 1'b1, msg[i]);
      #1;
      chk({name, " ready"}, req_ready, exp_rdy);
      tick();
      chk({name, " chk_char"}, chk_char, msg[i]);
    end
    e = cyc;
    drive(s, 1'b0, CHAR_FILL);
  endtask

  typedef struct {
    logic [N-1:0] valid;
    logic [N-1:0] rdy;
    int           src;
  } vec_t;
  vec_t tbl[11];

  initial begin
    string m;
    int e, e0, e2, i0, i2, nv;
    logic [N-1:0] exp_rdy;
    logic [7:0]   exp_c;

    // Single '#' messages: pure round-robin, pointer starts at N-1.
    tbl[0]  = '{4'b0000, 4'b0000, -1};
    tbl[1]  = '{4'b1010, 4'b0010, 1};
    tbl[2]  = '{4'b1010, 4'b1000, 3};
    tbl[3]  = '{4'b0001, 4'b0001, 0};
    tbl[4]  = '{4'b0001, 4'b0001, 0};
    tbl[5]  = '{4'b0110, 4'b0010, 1};
    tbl[6]  = '{4'b0011, 4'b0001, 0};
    tbl[7]  = '{4'b1111, 4'b0010, 1};
    tbl[8]  = '{4'b1100, 4'b0100, 2};
    tbl[9]  = '{4'b1001, 4'b1000, 3};
    tbl[10] = '{4'b1001, 4'b0001, 0};

    fake_type = FMT_REG;
    do_reset();
    chk("reset ready", req_ready, 0);
    for (int i = 0; i < 11; i++) begin
      req_char  = {N{CHAR_HASH}};
      req_valid = tbl[i].valid;
      #1;
      chk($sformatf("tbl%0d ready", i), req_ready, tbl[i].rdy);
      tick();
      chk($sformatf("tbl%0d chk_char", i), chk_char,
          (tbl[i].valid != 0) ? CHAR_HASH : CHAR_FILL);
    end
    req_valid = '0;
    tick(); tick(); tick();
    chk("tbl verdict count", vq.size(), 10);
    nv = 0;
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].src >= 0) begin
        if (vq.size() > nv) chk($sformatf("tbl verdict%0d src", nv), vq[nv].src, tbl[i].src);
        nv++;
      end
    end

    // 1: register message from src1.
    do_reset();
    fake_type = FMT_REG;
    send_msg("t1", 1, "^12@00003000: $ 1 <= 0000000a#", e);
    chk("t1 res_valid E+1", res_valid, 0);
    tick(); tick(); tick();
    chk("t1 verdict count", vq.size(), 1);
    expect_verdict("t1", 0, e + 2, 1, FMT_REG);

    // 2: src0 and src2 contend with memory messages.
    do_reset();
    fake_type = FMT_MEM;
    m = "^5@0000300c: *00000004 <= 0000ffff#";
    i0 = 0; i2 = 0; e0 = 0; e2 = 0;
    for (int c = 0; c < 2 * m.len() + 4 && (i0 < m.len() || i2 < m.len()); c++) begin
      drive(0, i0 < m.len(), (i0 < m.len()) ? m[i0] : CHAR_FILL);
      drive(2, i2 < m.len(), (i2 < m.len()) ? m[i2] : CHAR_FILL);
      #1;
      exp_rdy = (i0 < m.len()) ? 4'b0001 : 4'b0100;
      exp_c   = (i0 < m.len()) ? m[i0] : m[i2];
      chk("t2 ready", req_ready, exp_rdy);
      tick();
      chk("t2 chk_char", chk_char, exp_c);
      if (i0 < m.len()) begin
        i0++;
        if (i0 == m.len()) e0 = cyc;
      end else begin
        i2++;
        if (i2 == m.len()) e2 = cyc;
      end
    end
    req_valid = '0;
    tick(); tick(); tick();
    chk("t2 verdict count", vq.size(), 2);
    expect_verdict("t2 first", 0, e0 + 2, 0, FMT_MEM);
    expect_verdict("t2 second", 1, e2 + 2, 2, FMT_MEM);

    // 3: src3 bubbles mid-message; next grant wraps to src0.
    do_reset();
    fake_type = FMT_REG;
    send_msg("t3", 3, "^1@0000", e);
    drive(0, 1'b1, CHAR_HASH);
    drive(1, 1'b1, CHAR_CARET);
    tick();
    chk("t3 chk_char fill", chk_char, CHAR_FILL);
    chk("t3 abort", abort_pulse, 1);
    chk("t3 ready after bubble", req_ready, 4'b0001);
    tick();
    chk("t3 chk_char src0", chk_char, CHAR_HASH);
    chk("t3 abort clear", abort_pulse, 0);
    e = cyc;
    req_valid = '0;
    tick(); tick(); tick();
    chk("t3 verdict count", vq.size(), 1);
    expect_verdict("t3", 0, e + 2, 0, FMT_REG);

    // 4: src1 hits MAX_LEN with src2 waiting.
    do_reset();
    fake_type = FMT_REG;
    m = "^1@00003000:";
    while (m.len() < 64) m = {m, " "};
    drive(2, 1'b1, CHAR_HASH);
    for (int i = 0; i < 64; i++) begin
      drive(1, 1'b1, m[i]);
      #1;
      chk("t4 ready", req_ready, 4'b0010);
      tick();
      chk("t4 chk_char", chk_char, m[i]);
    end
    chk("t4 abort", abort_pulse, 1);
    drive(1, 1'b1, CHAR_CARET);
    #1;
    chk("t4 ready flush", req_ready, 0);
    tick();
    chk("t4 chk_char flush", chk_char, CHAR_FILL);
    chk("t4 abort clear", abort_pulse, 0);
    chk("t4 ready src2", req_ready, 4'b0100);
    tick();
    chk("t4 chk_char src2", chk_char, CHAR_HASH);
    e = cyc;
    req_valid = '0;
    tick(); tick(); tick();
    chk("t4 verdict count", vq.size(), 1);
    expect_verdict("t4", 0, e + 2, 2, FMT_REG);

    // 5: malformed message from src2.
    do_reset();
    fake_type = FMT_NONE;
    send_msg("t5", 2, "^123456@00003000: $1 <= 00000001#", e);
    tick(); tick(); tick();
    chk("t5 verdict count", vq.size(), 1);
    expect_verdict("t5", 0, e + 2, 2, FMT_NONE);

    // 6: reset one cycle after '#' drops the verdict.
    do_reset();
    fake_type = FMT_REG;
    send_msg("t6", 0, "^1@0#", e);
    reset = 1'b1;
    tick();
    chk("t6 chk_char", chk_char, CHAR_FILL);
    chk("t6 res_valid", res_valid, 0);
    chk("t6 res_src", res_src, 0);
    chk("t6 res_type", res_type, 0);
    chk("t6 abort", abort_pulse, 0);
    reset = 1'b0;
    tick();
    chk("t6 chk_char after", chk_char, CHAR_FILL);
    chk("t6 res_valid after", res_valid, 0);
    tick(); tick(); tick();
    chk("t6 verdict count", vq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
